instr_loader: RTL and testbench

Instruction encoder and loader for the single-cycle RV32I core: the writing end of the instruction path whose reading end is the control unit. It accepts field-level instruction requests (R, I-ALU, LW, SW, BEQ) over a valid/ready handshake, packs them into 32-bit RV32I words, and writes them sequentially into instruction memory from address 0. The opcodes produced are exactly the set the main decoder recognises, so every loaded word is decodable by the control unit.

---
 rtl/instr_loader.sv | 151 +++++++++++++++
 tb/tb_instr_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - RV32I field-level instruction encoder and sequential instruction-memory loader (optional INSTR_LOADER_CHECKSUM_EN)
module instr_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              inValid,
    output logic              inReady,
    input  logic [2:0]        kind,
    input  logic [2:0]        f3,
    input  logic              f7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [12:0]       imm,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [31:0]       memWdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic              loaded,
    output logic [31:0]       checksum
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ADDR_W:0] FULL_COUNT = DEPTH[ADDR_W:0];

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [31:0] enc_word;
    logic        kind_legal;
    logic        accept;
    logic        write_now;
    logic        unused_imm0;

    // BEQ offsets are halfword aligned, so bit 0 carries no information
    assign unused_imm0 = imm[0];

    // Pack the request fields into an RV32I word; opcodes match the core's main decoder
    always_comb begin
        enc_word   = 32'h0;
        kind_legal = 1'b1;
        case (kind)
            3'd0: enc_word = {(f7 ? 7'b0100000 : 7'b0000000), rs2, rs1, f3, rd, 7'b0110011};
            3'd1: enc_word = {imm[11:0], rs1, f3, rd, 7'b0010011};
            3'd2: enc_word = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
            3'd3: enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            3'd4: enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
            default: kind_legal = 1'b0;
        endcase
    end

    assign full    = (count_q == FULL_COUNT);
    assign inReady = (state_q == S_LOAD) && !full;
    // start has priority: a request presented alongside start is dropped
    assign accept    = inValid && inReady && !start;
    assign write_now = accept && kind_legal;

    // Next-state logic: start restarts from address 0 in any state, finish only leaves LOAD
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (start) begin
            state_d = S_LOAD;
            count_d = '0;
            err_d   = 1'b0;
        end else if (state_q == S_LOAD) begin
            if (write_now) begin
                we_d    = 1'b1;
                addr_d  = count_q[ADDR_W-1:0];
                wdata_d = enc_word;
                count_d = count_q + 1'b1;
            end else if (accept) begin
                err_d = 1'b1;
            end
            if (finish) begin
                state_d = S_DONE;
            end
        end
    end

    // Registered state and write port; reset returns everything to zero in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [31:0] cks_q, cks_d;

    // Running XOR of every word written since the last start
    always_comb begin
        cks_d = cks_q;
        if (start) begin
            cks_d = 32'h0;
        end else if (write_now) begin
            cks_d = cks_q ^ enc_word;
        end
    end

    // Checksum register advances on the same edge as count
    always_ff @(posedge clk) begin
        if (rst) begin
            cks_q <= 32'h0;
        end else begin
            cks_q <= cks_d;
        end
    end

    assign checksum = cks_q;
`else
    assign checksum = 32'h0;
`endif

    assign memWe    = we_q;
    assign memAddr  = addr_q;
    assign memWdata = wdata_q;
    assign count    = count_q;
    assign err      = err_q;
    assign loaded   = (state_q == S_DONE);

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - randomized self-checking bench for instr_loader against a behavioural model
module tb_instr_loader;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst, start, finish, inValid, inReady;
    logic [2:0]        kind, f3;
    logic              f7;
    logic [4:0]        rd, rs1, rs2;
    logic [12:0]       imm;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [31:0]       memWdata;
    logic [ADDR_W:0]   count;
    logic              full, err, loaded;
    logic [31:0]       checksum;

    instr_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .inValid(inValid), .inReady(inReady), .kind(kind), .f3(f3), .f7(f7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .count(count), .full(full), .err(err), .loaded(loaded), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: program state as plain integers
    int          m_state;   // 0 idle, 1 loading, 2 done
    int          m_count;
    bit          m_err;
    logic [31:0] m_cks;
    bit          p_we;
    int          l_addr;
    logic [31:0] l_data;
    logic [31:0] dut_mem [DEPTH];

    function automatic logic [31:0] ref_enc(input int k, input int fn3, input int fn7,
                                            input int d, input int s1, input int s2, input int im);
        logic [31:0] w;
        case (k)
            0: w = (fn7 != 0 ? 32'h4000_0000 : 32'h0) | (s2 << 20) | (s1 << 15) | (fn3 << 12) | (d << 7) | 32'h33;
            1: w = ((im & 'hFFF) << 20) | (s1 << 15) | (fn3 << 12) | (d << 7) | 32'h13;
            2: w = ((im & 'hFFF) << 20) | (s1 << 15) | (2 << 12) | (d << 7) | 32'h03;
            3: w = (((im >> 5) & 'h7F) << 25) | (s2 << 20) | (s1 << 15) | (2 << 12) | ((im & 'h1F) << 7) | 32'h23;
            default: w = (((im >> 12) & 1) << 31) | (((im >> 5) & 'h3F) << 25) | (s2 << 20) | (s1 << 15)
                         | (((im >> 1) & 'hF) << 8) | (((im >> 11) & 1) << 7) | 32'h63;
        endcase
        return w;
    endfunction

    task automatic model_reset();
        m_state = 0; m_count = 0; m_err = 0; m_cks = 0;
        p_we = 0; l_addr = 0; l_data = 0;
    endtask

    // One clock cycle: drive at the falling edge, compare outputs, advance the model
    task automatic drive(input bit st, input bit fin, input bit v, input int k, input int fn3,
                         input int fn7, input int d, input int s1, input int s2, input int im);
        bit          ready;
        logic [31:0] w;
        start = st; finish = fin; inValid = v; kind = 3'(k); f3 = 3'(fn3); f7 = 1'(fn7);
        rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2); imm = 13'(im);
        #1;
        ready = (m_state == 1) && (m_count < DEPTH);
        check_eq("inReady", 32'(inReady), 32'(ready));
        check_eq("memWe", 32'(memWe), 32'(p_we));
        check_eq("memAddr", 32'(memAddr), 32'(l_addr));
        check_eq("memWdata", memWdata, l_data);
        check_eq("count", 32'(count), 32'(m_count));
        check_eq("full", 32'(full), 32'(m_count == DEPTH));
        check_eq("err", 32'(err), 32'(m_err));
        check_eq("loaded", 32'(loaded), 32'(m_state == 2));
`ifdef INSTR_LOADER_CHECKSUM_EN
        check_eq("checksum", checksum, m_cks);
`else
        check_eq("checksum", checksum, 32'h0);
`endif
        if (memWe) dut_mem[memAddr] = memWdata;
        p_we = 0;
        if (st) begin
            m_state = 1; m_count = 0; m_err = 0; m_cks = 0;
        end else if (m_state == 1) begin
            if (v && ready) begin
                if (k <= 4) begin
                    w = ref_enc(k, fn3 & 7, fn7 & 1, d & 31, s1 & 31, s2 & 31, im & 'h1FFF);
                    p_we = 1; l_addr = m_count; l_data = w;
                    m_count++; m_cks ^= w;
                end else begin
                    m_err = 1;
                end
            end
            if (fin) m_state = 2;
        end
        @(negedge clk);
    endtask

    task automatic rnd(input bit st, input bit fin, input bit v, input int k);
        drive(st, fin, v, k, int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 8191)));
    endtask

    task automatic do_reset(input bit st);
        rst = 1; start = st; finish = 1'($urandom); inValid = 1; kind = 3'($urandom);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    initial begin
        rst = 1; start = 0; finish = 0; inValid = 0; kind = 0; f3 = 0; f7 = 0;
        rd = 0; rs1 = 0; rs2 = 0; imm = 0;
        for (int i = 0; i < DEPTH; i++) dut_mem[i] = 32'h0;
        @(negedge clk);
        do_reset(1'b0);

        // Reset values, then IDLE ignores requests
        #1;
        check_eq("rst_inReady", 32'(inReady), 32'h0);
        check_eq("rst_memWe", 32'(memWe), 32'h0);
        check_eq("rst_count", 32'(count), 32'h0);
        check_eq("rst_checksum", checksum, 32'h0);
        @(negedge clk);
        rnd(0, 0, 1, 0);

        // Two R words; the request alongside start is dropped
        drive(1, 0, 1, 0, 0, 0, 3, 1, 2, 0);
        drive(0, 0, 1, 0, 0, 0, 3, 1, 2, 0);
        drive(0, 0, 1, 0, 0, 1, 3, 1, 2, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("tp_r0", dut_mem[0], 32'h002081B3);
        check_eq("tp_r1", dut_mem[1], 32'h402081B3);
        check_eq("tp_count2", 32'(count), 32'd2);
`ifdef INSTR_LOADER_CHECKSUM_EN
        check_eq("tp_cks", checksum, 32'h40000000);
`endif

        // I-ALU, LW, SW back-to-back, then BEQ and finish
        drive(0, 0, 1, 1, 0, 0, 1, 0, 0, 5);
        drive(0, 0, 1, 2, 0, 0, 2, 1, 0, 8);
        drive(0, 0, 1, 3, 0, 0, 0, 0, 2, 4);
        drive(0, 0, 1, 4, 0, 0, 0, 1, 2, -8);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        check_eq("tp_addi", dut_mem[2], 32'h00500093);
        check_eq("tp_lw", dut_mem[3], 32'h0080A103);
        check_eq("tp_sw", dut_mem[4], 32'h00202223);
        check_eq("tp_beq", dut_mem[5], 32'hFE208CE3);
        check_eq("tp_loaded", 32'(loaded), 32'h1);
        check_eq("tp_done_ready", 32'(inReady), 32'h0);

        // Illegal kind between two legal words
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 7, 1, 9, 8, 7, 0);
        drive(0, 0, 1, 6, 0, 0, 1, 1, 1, 1);
        drive(0, 0, 1, 1, 3, 0, 4, 5, 0, 100);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("ill_err", 32'(err), 32'h1);
        check_eq("ill_addr", 32'(memAddr), 32'h1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("ill_clear", 32'(err), 32'h0);

        // Fill to DEPTH, stall, then restart mid-stall
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) rnd(0, 0, 1, int'($urandom_range(0, 4)));
        for (int i = 0; i < 4; i++) rnd(0, 0, 1, int'($urandom_range(0, 4)));
        check_eq("fill_full", 32'(full), 32'h1);
        check_eq("fill_count", 32'(count), 32'd64);
        rnd(1, 0, 1, 0);
        rnd(0, 0, 1, 1);
        rnd(0, 0, 0, 0);
        check_eq("restart_addr", 32'(memAddr), 32'h0);
        check_eq("restart_count", 32'(count), 32'h1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 15));
            rnd(($urandom_range(0, 39) == 0), ($urandom_range(0, 49) == 0),
                ($urandom_range(0, 3) != 0), (r == 0) ? int'($urandom_range(5, 7)) : (r % 5));
        end

        // Reset wins over start
        rnd(1, 0, 0, 0);
        rnd(0, 0, 1, 0);
        do_reset(1'b1);
        rnd(0, 0, 1, 0);
        rnd(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
